// File: rtl/tristate_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tristate_bus_ctrl
// Description : Round-robin owner of a shared single-wire tri-state bus built
//               from NAND tri-state drivers. One driver at a time gets its
//               enable. The enable is held SETTLE cycles and then the resolved
//               wire is captured. A TURN-cycle gap with every enable low
//               follows each window, so one driver's pmos/nmos turn-off never
//               overlaps the next driver's turn-on.
//
// Parameters  : N       number of drivers (2..8)
//               SETTLE  enable cycles before the bus is sampled (>= 1)
//               TURN    all-enables-low cycles after each window (>= 1)
//
// Ports       : clk         rising-edge clock
//               rst         synchronous active-high reset
//               req[N]      request vector, bit i = driver i wants the bus
//               bus         resolved shared wire (0/1/z/x)
//               en[N]       one-hot or all-zero driver enables
//               grant_id    index of the current or last granted driver
//               data_out    last captured bus value (1 only if bus was 1)
//               data_valid  one-cycle pulse when data_out/bus_fault update
//               bus_fault   captured value was z or x
//               busy        high while in DRIVE or TURN
//
// Revision    : 1.0 - initial release
// ============================================================================
module tristate_bus_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 2,
  parameter int TURN   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 bus,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 data_out,
  output logic                 data_valid,
  output logic                 bus_fault,
  output logic                 busy
);

  localparam int c_IDW     = $clog2(N);
  localparam int c_CNT_MAX = (SETTLE > TURN) ? SETTLE : TURN;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_SETTLE = c_CNT_W'(SETTLE);
  localparam logic [c_CNT_W-1:0] c_TURN   = c_CNT_W'(TURN);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
  localparam logic [c_IDW-1:0]   c_LAST_RST = c_IDW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_IDW-1:0]   r_last;

  logic               w_found;
  logic [c_IDW-1:0]   w_winner;
  logic [c_IDW-1:0]   w_cand;
  logic [N-1:0]       w_onehot;

  // Round-robin search: start one past the last winner and wrap at N-1, so
  // the first requester found in that order wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = c_IDW'((int'(r_last) + k) % N);
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin
    w_onehot           = '0;
    w_onehot[w_winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= c_LAST_RST;
      en         <= '0;
      grant_id   <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      bus_fault  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            en       <= w_onehot;
            grant_id <= w_winner;
            r_last   <= w_winner;
            r_cnt    <= c_ONE;
            busy     <= 1'b1;
            r_state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (r_cnt < c_SETTLE) begin
            r_cnt <= r_cnt + c_ONE;
          end else begin
            // A floating or contended wire reads as 0 with the fault flag set.
            data_out   <= (bus === 1'b1);
            bus_fault  <= (bus !== 1'b0) && (bus !== 1'b1);
            data_valid <= 1'b1;
            en         <= '0;
            r_cnt      <= c_ONE;
            r_state    <= S_TURN;
          end
        end
        S_TURN: begin
          if (r_cnt < c_TURN) begin
            r_cnt <= r_cnt + c_ONE;
          end else begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          en      <= '0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tristate_bus_ctrl
// Description : Bench for tristate_bus_ctrl. It models the NAND tri-state
//               drivers on the wire and keeps a transaction-timeline reference
//               of the controller. It runs directed scenarios followed by
//               random traffic and compares every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tristate_bus_ctrl;

  localparam int N      = 4;
  localparam int SETTLE = 2;
  localparam int TURN   = 1;
  localparam int IDW    = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic           bus_w;
  logic [N-1:0]   en;
  logic [IDW-1:0] grant_id;
  logic           data_out;
  logic           data_valid;
  logic           bus_fault;
  logic           busy;

  // Driver inputs: a/b of each NAND driver, and whether it is fitted at all.
  logic [N-1:0]   drv_a;
  logic [N-1:0]   drv_b;
  logic [N-1:0]   drv_present;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: expected outputs after the most recent edge.
  logic [N-1:0]   m_en;
  logic [IDW-1:0] m_gid;
  logic [IDW-1:0] m_last;
  logic           m_dout, m_dv, m_fault, m_busy, m_active;
  int             m_edge;
  int             m_gk;

  always #10 clk = ~clk;

  tristate_bus_ctrl #(.N(N), .SETTLE(SETTLE), .TURN(TURN)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .bus        (bus_w),
    .en         (en),
    .grant_id   (grant_id),
    .data_out   (data_out),
    .data_valid (data_valid),
    .bus_fault  (bus_fault),
    .busy       (busy)
  );

  // Resolved wire: an enabled fitted driver drives NAND(a,b), otherwise z.
  always_comb begin
    bus_w = 1'bz;
    if ($countones(en) > 1) begin
      bus_w = 1'bx;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (en[i] && drv_present[i]) bus_w = ~(drv_a[i] & drv_b[i]);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Timeline model: a grant at edge k holds en through edge k+SETTLE, where
  // the wire is captured, and the bus is free again after edge k+SETTLE+TURN.
  task automatic model_step();
    int  d;
    bit  found;
    int  c;
    m_edge++;
    if (rst) begin
      m_en     = '0;
      m_gid    = '0;
      m_dout   = 1'b0;
      m_dv     = 1'b0;
      m_fault  = 1'b0;
      m_busy   = 1'b0;
      m_last   = IDW'(N - 1);
      m_active = 1'b0;
    end else begin
      m_dv = 1'b0;
      if (m_active) begin
        d = m_edge - m_gk;
        if (d == SETTLE) begin
          m_dout  = (bus_w === 1'b1);
          m_fault = (bus_w !== 1'b0) && (bus_w !== 1'b1);
          m_dv    = 1'b1;
          m_en    = '0;
        end
        if (d == SETTLE + TURN) begin
          m_busy   = 1'b0;
          m_active = 1'b0;
        end
      end else if (req != '0) begin
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          c = (int'(m_last) + k) % N;
          if (!found && req[c]) begin
            found    = 1'b1;
            m_en     = '0;
            m_en[c]  = 1'b1;
            m_gid    = IDW'(c);
            m_last   = IDW'(c);
            m_gk     = m_edge;
            m_busy   = 1'b1;
            m_active = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock: drive inputs at the falling edge, step the model, let the
  // rising edge happen, then compare on the next falling edge.
  task automatic cycle(input logic r, input logic [N-1:0] rq);
    rst = r;
    req = rq;
    #1;
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("en", 32'(en), 32'(m_en));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("bus_fault", 32'(bus_fault), 32'(m_fault));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("en_onehot", 32'($countones(en) <= 1), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (en[i] && drv_present[i] && drv_a[i] && drv_b[i])
        chk("bus_resolved", 32'($isunknown(bus_w)), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0);
  endtask

  initial begin
    m_edge      = 0;
    m_gk        = 0;
    rst         = 1'b1;
    req         = '0;
    drv_a       = '1;
    drv_b       = '1;
    drv_present = '1;
    @(negedge clk);

    // Reset state.
    cycle(1'b1, '0);
    cycle(1'b1, '0);
    idle(2);

    // Reset on the second DRIVE cycle: the transaction never completes.
    cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b0000);
    cycle(1'b1, 4'b0000);
    cycle(1'b1, 4'b0000);
    idle(6);

    // Single request, driver 2 with a=b=1 pulls the wire to 0.
    drv_a[2] = 1'b1;
    drv_b[2] = 1'b1;
    cycle(1'b0, 4'b0100);
    idle(7);

    // Fairness under continuous requests from reset.
    cycle(1'b1, '0);
    for (int i = 0; i < 25; i++) begin
      drv_a = 4'($urandom);
      drv_b = 4'($urandom);
      cycle(1'b0, 4'b1111);
    end

    // Wrap-around between drivers 3 and 0.
    for (int i = 0; i < 16; i++) cycle(1'b0, 4'b1001);
    idle(6);

    // Floating wire: driver 1 absent.
    drv_present = 4'b1101;
    cycle(1'b0, 4'b0010);
    idle(6);
    drv_present = '1;

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drv_a       = 4'($urandom);
      drv_b       = 4'($urandom);
      drv_present = 4'($urandom_range(0, 3) == 0 ? $urandom : 32'hF);
      cycle($urandom_range(0, 39) == 0,
            ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
